// File: rtl/ahb_fill_master.sv
// AHB-Lite master that writes word_count consecutive words of a fill value from dst_addr.
// Optional build macro FILL_INCR_PATTERN_EN: beat k writes fill_data + k instead of fill_data.
module ahb_fill_master (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        start,
    input  logic [31:0] dst_addr,
    input  logic [15:0] word_count,
    input  logic [31:0] fill_data,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic        HMASTLOCK,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic        HRESP
);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_XFER,
        S_LAST,
        S_FINISH
    } state_t;

    state_t      state_q,  state_d;
    logic [31:0] haddr_q,  haddr_d;
    logic [1:0]  htrans_q, htrans_d;
    logic        hwrite_q, hwrite_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic [31:0] data_q,   data_d;
    logic [15:0] remain_q, remain_d;
    logic        dphase_q, dphase_d;
    logic        busy_q,   busy_d;
    logic        done_q,   done_d;
    logic        error_q,  error_d;

    always_comb begin
        state_d  = state_q;
        haddr_d  = haddr_q;
        htrans_d = htrans_q;
        hwrite_d = hwrite_q;
        hwdata_d = hwdata_q;
        data_d   = data_q;
        remain_d = remain_q;
        dphase_d = dphase_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        error_d  = error_q;

        case (state_q)
            // FINISH accepts a new start exactly like IDLE so runs can chain on done.
            S_IDLE, S_FINISH: begin
                state_d  = S_IDLE;
                busy_d   = 1'b0;
                htrans_d = TRANS_IDLE;
                hwrite_d = 1'b0;
                dphase_d = 1'b0;
                if (start) begin
                    error_d = 1'b0;
                    if (word_count != 16'd0) begin
                        state_d  = S_XFER;
                        haddr_d  = dst_addr & ~32'h3;
                        remain_d = word_count;
                        data_d   = fill_data;
                        htrans_d = TRANS_NONSEQ;
                        hwrite_d = 1'b1;
                        busy_d   = 1'b1;
                    end else begin
                        state_d = S_FINISH;
                        done_d  = 1'b1;
                    end
                end
            end

            S_XFER: begin
                if (dphase_q && HRESP) begin
                    // First error cycle: cancel the pending address phase and end the run.
                    state_d  = S_FINISH;
                    htrans_d = TRANS_IDLE;
                    hwrite_d = 1'b0;
                    dphase_d = 1'b0;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    error_d  = 1'b1;
                end else if (HREADY) begin
                    hwdata_d = data_q;
                    dphase_d = 1'b1;
`ifdef FILL_INCR_PATTERN_EN
                    data_d   = data_q + 32'd1;
`else
                    data_d   = data_q;
`endif
                    if (remain_q == 16'd1) begin
                        state_d  = S_LAST;
                        htrans_d = TRANS_IDLE;
                        hwrite_d = 1'b0;
                        remain_d = 16'd0;
                    end else begin
                        haddr_d  = haddr_q + 32'd4;
                        remain_d = remain_q - 16'd1;
                    end
                end
            end

            S_LAST: begin
                if (HRESP) begin
                    state_d  = S_FINISH;
                    dphase_d = 1'b0;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    error_d  = 1'b1;
                end else if (HREADY) begin
                    state_d  = S_FINISH;
                    dphase_d = 1'b0;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= S_IDLE;
            haddr_q  <= 32'd0;
            htrans_q <= TRANS_IDLE;
            hwrite_q <= 1'b0;
            hwdata_q <= 32'd0;
            data_q   <= 32'd0;
            remain_q <= 16'd0;
            dphase_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            haddr_q  <= haddr_d;
            htrans_q <= htrans_d;
            hwrite_q <= hwrite_d;
            hwdata_q <= hwdata_d;
            data_q   <= data_d;
            remain_q <= remain_d;
            dphase_q <= dphase_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    assign HADDR     = haddr_q;
    assign HTRANS    = htrans_q;
    assign HWRITE    = hwrite_q;
    assign HWDATA    = hwdata_q;
    assign HSIZE     = 3'b010;
    assign HBURST    = 3'b000;
    assign HPROT     = 4'b0011;
    assign HMASTLOCK = 1'b0;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: doc/ahb_fill_master.md
# ahb_fill_master

AHB-Lite bus master that writes a run of consecutive 32-bit words, each holding a fill value, starting at a programmed word address. It is the initiator-side companion to the SoC's AHB-Lite slaves. It clears or paints regions of the pixel memory (or RAM) without CPU stores. It sits on a second AHB-Lite master port and drives the same address/control/write-data signals the CPU does. A local start/busy/done handshake starts each run.

## Interface
- No parameters.
- HCLK  in  1  system clock; all state updates on rising edge.
- HRESETn  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request; sampled only while idle.
- dst_addr  in  32  byte address of first word; bits [1:0] ignored (treated as 0).
- word_count  in  16  number of words to write; 0 is legal.
- fill_data  in  32  value written to every word (see Configuration).
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at end of run (normal or aborted).
- error  out  1  set if the run aborted on HRESP; held until next accepted start.
- HADDR  out  32  address-phase address.
- HTRANS  out  2  IDLE (00) or NONSEQ (10) only.
- HWRITE  out  1  high during every NONSEQ address phase.
- HSIZE  out  3  constant 3'b010 (word).
- HBURST  out  3  constant 3'b000 (SINGLE).
- HPROT  out  4  constant 4'b0011.
- HMASTLOCK  out  1  constant 0.
- HWDATA  out  32  data-phase write data.
- HREADY  in  1  transfer-complete from the interconnect.
- HRESP  in  1  error response.

## Operation
- Reset values: HTRANS=IDLE, HADDR=0, HWDATA=0, HWRITE=0, busy=0, done=0, error=0. The constant outputs are at their constant values.
- States: IDLE, XFER, LAST, FINISH.
- IDLE:
  - start=1 with word_count≠0: latch dst_addr (aligned), word_count and fill_data; clear error; go to XFER.
  - start=1 with word_count=0: go to FINISH with no bus activity.
- XFER: drive NONSEQ address phases back-to-back. Each beat is a single NONSEQ transfer.
  - The address phase of beat k+1 overlaps the data phase of beat k.
  - When HREADY=1, the address advances by 4 and the remaining count decrements.
  - Once the last address phase is accepted, go to LAST with HTRANS=IDLE.
- LAST: hold HWDATA for the final data phase until HREADY=1, then go to FINISH.
- FINISH: pulse done for one cycle, drop busy, return to IDLE.
- While HREADY=0: HADDR, HTRANS, HWRITE and HWDATA are held stable.
- HWDATA for a beat is driven in the cycle after that beat's address phase is accepted.
- Error handling (HRESP=1):
  - In the first error cycle (HREADY=0), drive HTRANS=IDLE in the next cycle.
  - No further NONSEQ is issued. Set error and go to FINISH.
  - The beat that was pending in the address phase is cancelled.
- Address arithmetic is 32-bit modulo 2^32; wrap from 0xFFFFFFFC to 0x00000000 is legal.
- start while busy is ignored. Input changes after start is accepted have no effect on the current run.
- Asserting HRESETn low mid-run returns all outputs to reset values immediately. The run is lost, and done is not pulsed.

## Timing
- Cycle 0: start sampled.
- Cycle 1: busy=1; first address phase (HADDR=dst, HTRANS=NONSEQ).
- With HREADY always high and N≥1:
  - address phases occupy cycles 1..N;
  - data phases occupy cycles 2..N+1;
  - done=1 and busy=0 in cycle N+2.
- Each HREADY-low cycle adds exactly one cycle of latency.
- word_count=0: done=1 in cycle 1; busy stays 0.
- Error on beat k: done no later than 2 cycles after HRESP first goes high.
- A new start is accepted in the cycle done is high.

## Configuration
- FILL_INCR_PATTERN_EN defined: each successive word is the previous value plus 1, modulo 2^32. Beat k writes fill_data+k. This is the test-pattern mode.
- FILL_INCR_PATTERN_EN undefined: every word equals the latched fill_data.

## Test plan
- dst=0x5000_0000, count=4, fill=0xFFFF_FFFF, HREADY=1: HADDR 0x5000_0000..0x5000_000C in cycles 1–4; HWDATA 0xFFFF_FFFF in cycles 2–5; done in cycle 6.
- count=3, HREADY low for 2 cycles during beat 1's data phase: HADDR and HWDATA held stable; done in cycle 7; exactly 3 writes.
- count=0: done in cycle 1; HTRANS stays IDLE; busy never rises.
- count=5, HRESP two-cycle error on beat 2:
  - HTRANS=IDLE the cycle after HRESP first goes high;
  - no addresses at or beyond 0x…0C are issued;
  - error=1; done pulses.
- dst=0xFFFF_FFF8, count=3, fill=0x10 with FILL_INCR_PATTERN_EN: addresses FFF8, FFFC, 0000 with data 0x10, 0x11, 0x12. Without the macro, all data is 0x10.
- HRESETn low in cycle 3 of a 6-word run: outputs return to reset values immediately; no done pulse; a following start runs normally.
